// File: rtl/shift_operand_sequencer_if.sv
// Handshake/bus bundle between decode, the port-B register read and the shifter-operand sequencer.
// The master side issues requests and supplies port-B data; the slave side is the sequencer.
interface shift_operand_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic [31:0] rm_data;
  logic        c_in;
  logic [31:0] rs_data;
  logic        rf_rd_b;
  logic [3:0]  rf_addr_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        shift_cout;
  logic        unsupported;

  modport master (
    output start, ir, rm_data, c_in, rs_data,
    input  rf_rd_b, rf_addr_b, busy, done, result, shift_cout, unsupported
  );

  modport slave (
    input  start, ir, rm_data, c_in, rs_data,
    output rf_rd_b, rf_addr_b, busy, done, result, shift_cout, unsupported
  );
endinterface

// File: rtl/shift_operand_sequencer.sv
// ARM shifter operand / carry-out via a 1-bit-per-cycle engine; done at cycle n+1 (n+2 for reg shifts).
// No backpressure: start is only taken in IDLE, and requests seen while busy are dropped.
module shift_operand_sequencer (
  input logic                    clk,
  input logic                    rst_n,
  shift_operand_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ_RS, SHIFT, DONE} state_t;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  state_t      state, state_nxt;
  logic [31:0] work;
  logic        cout_q;
  logic [5:0]  cnt;
  logic [1:0]  sh_type;
  logic        rrx;
  logic        unsup_q;
  logic [3:0]  rs_addr;

  logic        accept;
  logic        is_imm_sh, is_reg_sh, is_immed;
  logic [4:0]  amt5;
  logic [7:0]  rs_amt;
  logic [5:0]  n_imm, n_reg;
  logic        rd_b;
  logic        unused_bits;

  assign accept    = (state == IDLE) && bus.start;
  assign is_imm_sh = (bus.ir[27:25] == 3'b000) && !bus.ir[4];
  assign is_reg_sh = (bus.ir[27:25] == 3'b000) && bus.ir[4] && !bus.ir[7];
  assign is_immed  = (bus.ir[27:25] == 3'b001);
  assign amt5      = bus.ir[11:7];
  assign rs_amt    = bus.rs_data[7:0];
  assign unused_bits = ^{bus.ir[31:28], bus.ir[24:12], bus.rs_data[31:8]};

  // Shift count for forms fully known at accept; reg shifts get theirs in READ_RS.
  always_comb begin
    n_imm = 6'd0;
    if (is_immed) begin
      n_imm = {1'b0, bus.ir[11:8], 1'b0};
    end else if (is_imm_sh) begin
      case (bus.ir[6:5])
        SH_LSL:         n_imm = {1'b0, amt5};
        SH_LSR, SH_ASR: n_imm = (amt5 == 5'd0) ? 6'd32 : {1'b0, amt5};
        default:        n_imm = (amt5 == 5'd0) ? 6'd1  : {1'b0, amt5};
      endcase
    end
  end

  always_comb begin
    n_reg = 6'd0;
    case (sh_type)
      SH_LSL, SH_LSR: n_reg = (rs_amt >= 8'd33) ? 6'd33 : rs_amt[5:0];
      SH_ASR:         n_reg = (rs_amt >= 8'd32) ? 6'd32 : rs_amt[5:0];
      default:        n_reg = {1'b0, rs_amt[4:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = is_reg_sh ? READ_RS : SHIFT;
      READ_RS: state_nxt = SHIFT;
      SHIFT:   if (cnt == 6'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work    <= 32'd0;
      cout_q  <= 1'b0;
      cnt     <= 6'd0;
      sh_type <= 2'd0;
      rrx     <= 1'b0;
      unsup_q <= 1'b0;
      rs_addr <= 4'd0;
    end else if (accept) begin
      work    <= is_immed ? {24'd0, bus.ir[7:0]} : bus.rm_data;
      cout_q  <= bus.c_in;
      cnt     <= n_imm;
      sh_type <= is_immed ? SH_ROR : bus.ir[6:5];
      rrx     <= is_imm_sh && (bus.ir[6:5] == SH_ROR) && (amt5 == 5'd0);
      unsup_q <= !(is_imm_sh || is_reg_sh || is_immed);
      rs_addr <= bus.ir[11:8];
    end else if (state == READ_RS) begin
      cnt <= n_reg;
      // ROR by a non-zero multiple of 32 leaves the value alone but carries out bit 31.
      if (sh_type == SH_ROR && rs_amt != 8'd0 && rs_amt[4:0] == 5'd0)
        cout_q <= work[31];
    end else if (state == SHIFT && cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
      case (sh_type)
        SH_LSL: begin
          cout_q <= work[31];
          work   <= {work[30:0], 1'b0};
        end
        SH_LSR: begin
          cout_q <= work[0];
          work   <= {1'b0, work[31:1]};
        end
        SH_ASR: begin
          cout_q <= work[0];
          work   <= {work[31], work[31:1]};
        end
        default: begin
          cout_q <= work[0];
          work   <= {(rrx ? cout_q : work[0]), work[31:1]};
        end
      endcase
    end
  end

  assign rd_b            = (state == READ_RS);
  assign bus.rf_rd_b     = rd_b;
  assign bus.rf_addr_b   = rd_b ? rs_addr : 4'd0;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == SHIFT) && (cnt == 6'd0);
  assign bus.result      = work;
  assign bus.shift_cout  = cout_q;
  assign bus.unsupported = unsup_q;
endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Bench for shift_operand_sequencer: directed table, reset-abort sequence, then random
// instructions checked against an arithmetic model of the ARM shifter operand rules.
module tb_shift_operand_sequencer;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  shift_operand_sequencer_if bus ();

  shift_operand_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] rm;
    logic        c;
    logic [31:0] rs;
    logic        poke;
    logic [31:0] e_res;
    logic        e_c;
    logic        e_u;
    int          e_lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        u;
    int          lat;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int r);
    if (r == 0) return v;
    return (v >> r) | (v << (32 - r));
  endfunction

  // Direct evaluation of the shifter-operand definitions; latency = cycles until done.
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] rm,
                                 input logic c, input logic [31:0] rs);
    exp_t e;
    int   a;
    int   n;
    e.res = rm;
    e.c   = c;
    e.u   = 1'b0;
    e.lat = 1;
    n     = 0;
    if (ir[27:25] == 3'b000 && !ir[4]) begin
      a = int'(ir[11:7]);
      case (ir[6:5])
        2'd0: begin
          n = a;
          if (a != 0) begin e.res = rm << a; e.c = rm[32 - a]; end
        end
        2'd1, 2'd2: begin
          if (a == 0) a = 32;
          n   = a;
          e.c = rm[a - 1];
          if (ir[6:5] == 2'd1) e.res = (a == 32) ? 32'd0 : rm >> a;
          else                 e.res = (a == 32) ? {32{rm[31]}} : 32'($signed(rm) >>> a);
        end
        default: begin
          if (a == 0) begin n = 1; e.res = {c, rm[31:1]}; e.c = rm[0]; end
          else begin n = a; e.res = rotr(rm, a); e.c = rm[a - 1]; end
        end
      endcase
      e.lat = n + 1;
    end else if (ir[27:25] == 3'b000 && ir[4] && !ir[7]) begin
      a = int'(rs[7:0]);
      case (ir[6:5])
        2'd0: begin
          n = (a > 33) ? 33 : a;
          if (a != 0 && a < 32) begin e.res = rm << a; e.c = rm[32 - a]; end
          else if (a == 32) begin e.res = 0; e.c = rm[0]; end
          else if (a > 32) begin e.res = 0; e.c = 1'b0; end
        end
        2'd1: begin
          n = (a > 33) ? 33 : a;
          if (a != 0 && a < 32) begin e.res = rm >> a; e.c = rm[a - 1]; end
          else if (a == 32) begin e.res = 0; e.c = rm[31]; end
          else if (a > 32) begin e.res = 0; e.c = 1'b0; end
        end
        2'd2: begin
          n = (a > 32) ? 32 : a;
          if (a != 0 && a < 32) begin e.res = 32'($signed(rm) >>> a); e.c = rm[a - 1]; end
          else if (a >= 32) begin e.res = {32{rm[31]}}; e.c = rm[31]; end
        end
        default: begin
          n = a % 32;
          if (a != 0 && n == 0) e.c = rm[31];
          else if (n != 0) begin e.res = rotr(rm, n); e.c = rm[n - 1]; end
        end
      endcase
      e.lat = n + 2;
    end else if (ir[27:25] == 3'b001) begin
      n     = 2 * int'(ir[11:8]);
      e.res = rotr({24'd0, ir[7:0]}, n);
      if (n != 0) e.c = e.res[31];
      e.lat = n + 1;
    end else begin
      e.u = 1'b1;
    end
    return e;
  endfunction

  // Starts from a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [31:0] ir_v, input logic [31:0] rm_v, input logic c_v,
                        input logic [31:0] rs_v, input logic poke, input logic [31:0] e_res,
                        input logic e_c, input logic e_u, input int e_lat);
    int cyc;
    bit is_reg;
    is_reg = (ir_v[27:25] == 3'b000) && ir_v[4] && !ir_v[7];
    bus.start   = 1'b1;
    bus.ir      = ir_v;
    bus.rm_data = rm_v;
    bus.c_in    = c_v;
    bus.rs_data = rs_v;
    @(negedge clk);
    cyc = 1;
    if (poke) begin
      bus.ir      = 32'hE3A004FF;
      bus.rm_data = ~rm_v;
      bus.c_in    = ~c_v;
    end else begin
      bus.start = 1'b0;
    end
    chk("rf_rd_b", {31'd0, bus.rf_rd_b}, {31'd0, is_reg});
    if (is_reg) chk("rf_addr_b", {28'd0, bus.rf_addr_b}, {28'd0, ir_v[11:8]});
    while (cyc <= 80 && !bus.done) begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_cycle", 32'(cyc), 32'(e_lat));
    chk("result", bus.result, e_res);
    chk("shift_cout", {31'd0, bus.shift_cout}, {31'd0, e_c});
    chk("unsupported", {31'd0, bus.unsupported}, {31'd0, e_u});
    @(negedge clk);
    chk("done_pulse_width", {31'd0, bus.done}, 32'd0);
    chk("result_held", bus.result, e_res);
    @(negedge clk);
    chk("busy_back_to_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  vec_t tbl [12];

  initial begin
    exp_t e;
    int   kind;
    int   done_seen;
    logic [31:0] ir_r;
    logic [31:0] rs_r;
    logic        pk;

    vectors     = 0;
    miscompares = 0;

    tbl[0]  = '{32'hE1A00201, 32'h8000000F, 1'b0, 32'h0,   1'b0, 32'h000000F0, 1'b0, 1'b0, 5};
    tbl[1]  = '{32'hE1A00061, 32'h00000003, 1'b1, 32'h0,   1'b0, 32'h80000001, 1'b1, 1'b0, 2};
    tbl[2]  = '{32'hE1A00231, 32'h80000000, 1'b0, 32'h20,  1'b0, 32'h00000000, 1'b1, 1'b0, 34};
    tbl[3]  = '{32'hE1A00231, 32'h80000000, 1'b0, 32'h21,  1'b0, 32'h00000000, 1'b0, 1'b0, 35};
    tbl[4]  = '{32'hE1A00231, 32'h12345678, 1'b1, 32'h100, 1'b1, 32'h12345678, 1'b1, 1'b0, 2};
    tbl[5]  = '{32'hE3A004FF, 32'h00000000, 1'b0, 32'h0,   1'b0, 32'hFF000000, 1'b1, 1'b0, 9};
    tbl[6]  = '{32'hE0000090, 32'h12345678, 1'b1, 32'h0,   1'b0, 32'h12345678, 1'b1, 1'b1, 1};
    tbl[7]  = '{32'hE1A00021, 32'h80000000, 1'b0, 32'h0,   1'b0, 32'h00000000, 1'b1, 1'b0, 33};
    tbl[8]  = '{32'hE1A00251, 32'h80000000, 1'b0, 32'h28,  1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 34};
    tbl[9]  = '{32'hE1A00271, 32'h80000001, 1'b0, 32'h20,  1'b0, 32'h80000001, 1'b1, 1'b0, 2};
    tbl[10] = '{32'hE5900000, 32'h00000005, 1'b0, 32'h0,   1'b0, 32'h00000005, 1'b0, 1'b1, 1};
    tbl[11] = '{32'hE3A00001, 32'h00000000, 1'b1, 32'h0,   1'b0, 32'h00000001, 1'b1, 1'b0, 1};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.ir      = 32'd0;
    bus.rm_data = 32'd0;
    bus.c_in    = 1'b0;
    bus.rs_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_cout", {31'd0, bus.shift_cout}, 32'd0);
    chk("reset_unsupported", {31'd0, bus.unsupported}, 32'd0);
    chk("reset_rf_rd_b", {31'd0, bus.rf_rd_b}, 32'd0);
    chk("reset_rf_addr_b", {28'd0, bus.rf_addr_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].ir, tbl[i].rm, tbl[i].c, tbl[i].rs, tbl[i].poke,
             tbl[i].e_res, tbl[i].e_c, tbl[i].e_u, tbl[i].e_lat);

    // Reset in the middle of a long shift must abort without a done pulse.
    bus.start   = 1'b1;
    bus.ir      = 32'hE1A00021;
    bus.rm_data = 32'h80000000;
    bus.c_in    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_cout", {31'd0, bus.shift_cout}, 32'd0);
    rst_n     = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_op(tbl[0].ir, tbl[0].rm, tbl[0].c, tbl[0].rs, 1'b0,
           tbl[0].e_res, tbl[0].e_c, tbl[0].e_u, tbl[0].e_lat);

    for (int k = 0; k < 150; k++) begin
      kind = int'($urandom_range(0, 3));
      ir_r = $urandom;
      case (kind)
        0: begin ir_r[27:25] = 3'b000; ir_r[4] = 1'b0; end
        1: begin ir_r[27:25] = 3'b000; ir_r[4] = 1'b1; ir_r[7] = 1'b0; end
        2: ir_r[27:25] = 3'b001;
        default: ;
      endcase
      rs_r = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      pk   = (kind == 1) && ($urandom_range(0, 3) == 0);
      bus.c_in = 1'($urandom_range(0, 1));
      bus.rm_data = $urandom;
      e = model(ir_r, bus.rm_data, bus.c_in, rs_r);
      run_op(ir_r, bus.rm_data, bus.c_in, rs_r, pk, e.res, e.c, e.u, e.lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
